sd_speicherer: RTL and testbench
================================

// Module: sd_speicherer
// PURPOSE
//  RAM-to-SD-card saver; the write-direction counterpart of the boot loader.
//  On Start it writes a header word (word count - 1), then copies Wortanzahl 32-bit words
//  from RAM to consecutive SD word addresses through the SD writer interface.
//  The resulting image is in the same format the boot loader reads back.
//  Sits between the RAM port mux and the SD card writer; runs on the CPU clock.
// PARAMETERS
//  ADDR_W      15  RAM word-address width
//  GAP_CYCLES  31  idle cycles required between SD write requests (SD controller pacing)
// PORTS
//  Clock          in   1       system clock; all logic on rising edge
//  ResetN         in   1       synchronous, active-low reset
//  Start          in   1       1-cycle start request; sampled only in IDLE
//  StartAdresse   in   ADDR_W  first RAM word address
//  Wortanzahl     in   32      number of data words to save
//  SDBasis        in   32      SD word address for the header
//  Busy           out  1       high from the cycle after an accepted Start until FERTIG
//  Fertig         out  1       1-cycle pulse when the transfer is complete
//  Fehler         out  1       1-cycle pulse when Start is rejected (Wortanzahl == 0)
//  RAMLesenAn     out  1       RAM read request; held high until RAMDatenBereit
//  RAMAdresse     out  ADDR_W  RAM read address
//  RAMDatenRaus   in   32      RAM read data
//  RAMDatenBereit in   1       RAM read data valid
//  SDAdresse      out  32      SD word address; stable while SDSchreiben is high
//  SDDaten        out  32      SD write data; stable while SDSchreiben is high
//  SDSchreiben    out  1       1-cycle SD write request pulse
//  SDBusy         in   1       SD writer busy
// BEHAVIOUR
//  Reset: ResetN low at an edge puts the block in IDLE.
//   All outputs go to 0 on that edge, even mid-transfer; the transfer is aborted with no Fertig.
//  States:
//   IDLE -> GROESSE on Start with Wortanzahl != 0.
//     Latches the inputs, sets rest = Wortanzahl, idx = 0.
//   IDLE + Start with Wortanzahl == 0: Fehler pulses on the next cycle; state stays IDLE.
//   GROESSE: SDDaten = Wortanzahl - 1, SDAdresse = SDBasis.
//     Issues the SD pulse (see pacing), then -> WARTEN.
//   RAMLESEN: RAMLesenAn = 1, RAMAdresse = StartAdresse + idx (mod 2**ADDR_W, wraps).
//     On RAMDatenBereit: latch RAMDatenRaus, drop RAMLesenAn the next cycle, -> SDSCHREIBEN.
//   SDSCHREIBEN: SDDaten = latched word, SDAdresse = SDBasis + 1 + idx (32-bit wrap).
//     Issues the SD pulse, then -> WARTEN. idx += 1 and rest -= 1 on the pulse.
//   WARTEN: after GAP_CYCLES gap cycles (see pacing):
//     -> RAMLESEN if rest != 0, else -> FERTIG.
//   FERTIG: Fertig = 1 for exactly 1 cycle, Busy = 0 in the same cycle, -> IDLE.
//  SD pacing:
//   A pulse is issued only when SDBusy = 0 and the gap counter = 0.
//   The gap counter loads GAP_CYCLES on each pulse.
//   It decrements only in cycles where SDBusy = 0; SDBusy = 1 holds it.
//   The block never issues two pulses closer than GAP_CYCLES + 1 cycles apart.
//  Start while Busy: ignored, no side effects.
//  RAM ports are driven only in RAMLESEN; RAMLesenAn = 0 in all other states.
//  Latency per word: >= RAM latency + 1 + GAP_CYCLES + 1 cycles.
//  Total SD pulses: Wortanzahl + 1.
// CONFIGURATION
//  SD_PRUEFSUMME_EN defined:
//   A running XOR of all data words (header excluded) is kept.
//   After the last data word, one extra pulse writes the XOR to SDBasis + 1 + Wortanzahl,
//   followed by WARTEN, then FERTIG.
//   The header value is unchanged (Wortanzahl - 1).
//  SD_PRUEFSUMME_EN undefined: no checksum word; the FERTIG path is as above.
// TESTING
//  1. Wortanzahl=3, StartAdresse=0x10, SDBasis=0x100, RAM[0x10..0x12]=A,B,C
//     -> SD writes (0x100,2),(0x101,A),(0x102,B),(0x103,C); one Fertig pulse.
//  2. Start with Wortanzahl=0 -> Fehler pulses 1 cycle; Busy stays 0; no SD or RAM activity.
//  3. SDBusy held high 50 cycles after each pulse, GAP_CYCLES=31
//     -> each next pulse comes >=32 SDBusy-low cycles after SDBusy falls.
//  4. ResetN low during the 2nd data word -> next edge: all outputs 0, state IDLE;
//     no further SD pulses and no Fertig.
//  5. StartAdresse=2**ADDR_W-1, Wortanzahl=2 -> RAM reads at 0x7FFF then 0x0000 (ADDR_W=15).
//  6. SD_PRUEFSUMME_EN, data 0x0F,0xF0 -> 4th write (SDBasis+3, 0xFF); Start during Busy ignored.

Source files
------------

// File: rtl/sd_speicherer_if.sv
// RAM read port and SD writer port of the RAM-to-SD saver.
interface sd_speicherer_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              RAMLesenAn;
  logic [ADDR_W-1:0] RAMAdresse;
  logic [31:0]       RAMDatenRaus;
  logic              RAMDatenBereit;
  logic [31:0]       SDAdresse;
  logic [31:0]       SDDaten;
  logic              SDSchreiben;
  logic              SDBusy;

  modport master (
    output RAMLesenAn, RAMAdresse, SDAdresse, SDDaten, SDSchreiben,
    input  RAMDatenRaus, RAMDatenBereit, SDBusy
  );

  modport slave (
    input  RAMLesenAn, RAMAdresse, SDAdresse, SDDaten, SDSchreiben,
    output RAMDatenRaus, RAMDatenBereit, SDBusy
  );
endinterface

// File: rtl/sd_speicherer.sv
// RAM-to-SD saver: writes a header (count - 1) then copies RAM words to consecutive SD words.
// Optional trailing XOR checksum word when SD_PRUEFSUMME_EN is defined.
module sd_speicherer #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned GAP_CYCLES = 31
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAdresse,
  input  logic [31:0]       Wortanzahl,
  input  logic [31:0]       SDBasis,
  output logic              Busy,
  output logic              Fertig,
  output logic              Fehler,
  sd_speicherer_if.master   bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

`ifdef SD_PRUEFSUMME_EN
  typedef enum logic [2:0] {
    IDLE, GROESSE, RAMLESEN, SDSCHREIBEN, WARTEN, PRUEFSUMME, FERTIG
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, GROESSE, RAMLESEN, SDSCHREIBEN, WARTEN, FERTIG
  } state_e;
`endif

  state_e state_q, state_d;

  logic [ADDR_W-1:0] start_q, start_d;
  logic [DATA_W-1:0] anzahl_q, anzahl_d;
  logic [DATA_W-1:0] basis_q, basis_d;
  logic [DATA_W-1:0] rest_q, rest_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wort_q, wort_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              busy_q, busy_d;
  logic              fertig_q, fertig_d;
  logic              fehler_q, fehler_d;
  logic              ram_lesen_q, ram_lesen_d;
  logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
  logic [DATA_W-1:0] sd_adr_q, sd_adr_d;
  logic [DATA_W-1:0] sd_dat_q, sd_dat_d;
  logic              sd_wr_q, sd_wr_d;
  logic              sd_frei_c;

`ifdef SD_PRUEFSUMME_EN
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              pruef_done_q, pruef_done_d;
`endif

  assign sd_frei_c = !bus.SDBusy && (gap_q == '0);

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    anzahl_d    = anzahl_q;
    basis_d     = basis_q;
    rest_d      = rest_q;
    idx_d       = idx_q;
    wort_d      = wort_q;
    gap_d       = gap_q;
    fehler_d    = 1'b0;
    sd_wr_d     = 1'b0;
    sd_adr_d    = '0;
    sd_dat_d    = '0;
`ifdef SD_PRUEFSUMME_EN
    xor_d        = xor_q;
    pruef_done_d = pruef_done_q;
`endif

    // The pulse cycle itself does not count towards the gap, giving one cycle of margin.
    if (!sd_wr_q && !bus.SDBusy && (gap_q != '0)) begin
      gap_d = gap_q - GAP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Wortanzahl != '0) begin
            start_d  = StartAdresse;
            anzahl_d = Wortanzahl;
            basis_d  = SDBasis;
            rest_d   = Wortanzahl;
            idx_d    = '0;
`ifdef SD_PRUEFSUMME_EN
            xor_d        = '0;
            pruef_done_d = 1'b0;
`endif
            state_d  = GROESSE;
          end else begin
            fehler_d = 1'b1;
          end
        end
      end

      GROESSE: begin
        if (sd_frei_c) begin
          sd_wr_d  = 1'b1;
          sd_adr_d = basis_q;
          sd_dat_d = anzahl_q - DATA_W'(1);
          gap_d    = GAP_W'(GAP_CYCLES);
          state_d  = WARTEN;
        end
      end

      RAMLESEN: begin
        if (bus.RAMDatenBereit) begin
          wort_d  = bus.RAMDatenRaus;
          state_d = SDSCHREIBEN;
        end
      end

      SDSCHREIBEN: begin
        if (sd_frei_c) begin
          sd_wr_d  = 1'b1;
          sd_adr_d = basis_q + DATA_W'(1) + idx_q;
          sd_dat_d = wort_q;
          gap_d    = GAP_W'(GAP_CYCLES);
          idx_d    = idx_q + DATA_W'(1);
          rest_d   = rest_q - DATA_W'(1);
`ifdef SD_PRUEFSUMME_EN
          xor_d    = xor_q ^ wort_q;
`endif
          state_d  = WARTEN;
        end
      end

      WARTEN: begin
        if (gap_q == '0) begin
          if (rest_q != '0) begin
            state_d = RAMLESEN;
          end
`ifdef SD_PRUEFSUMME_EN
          else if (!pruef_done_q) begin
            state_d = PRUEFSUMME;
          end
`endif
          else begin
            state_d = FERTIG;
          end
        end
      end

`ifdef SD_PRUEFSUMME_EN
      // idx equals the word count here, so the checksum lands right after the last data word
      PRUEFSUMME: begin
        if (sd_frei_c) begin
          sd_wr_d      = 1'b1;
          sd_adr_d     = basis_q + DATA_W'(1) + idx_q;
          sd_dat_d     = xor_q;
          gap_d        = GAP_W'(GAP_CYCLES);
          pruef_done_d = 1'b1;
          state_d      = WARTEN;
        end
      end
`endif

      FERTIG: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE) && (state_d != FERTIG);
    fertig_d    = (state_d == FERTIG);
    ram_lesen_d = (state_d == RAMLESEN);
    ram_adr_d   = ram_lesen_d ? (start_q + ADDR_W'(idx_d)) : '0;
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      start_q     <= '0;
      anzahl_q    <= '0;
      basis_q     <= '0;
      rest_q      <= '0;
      idx_q       <= '0;
      wort_q      <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      fertig_q    <= 1'b0;
      fehler_q    <= 1'b0;
      ram_lesen_q <= 1'b0;
      ram_adr_q   <= '0;
      sd_adr_q    <= '0;
      sd_dat_q    <= '0;
      sd_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      anzahl_q    <= anzahl_d;
      basis_q     <= basis_d;
      rest_q      <= rest_d;
      idx_q       <= idx_d;
      wort_q      <= wort_d;
      gap_q       <= gap_d;
      busy_q      <= busy_d;
      fertig_q    <= fertig_d;
      fehler_q    <= fehler_d;
      ram_lesen_q <= ram_lesen_d;
      ram_adr_q   <= ram_adr_d;
      sd_adr_q    <= sd_adr_d;
      sd_dat_q    <= sd_dat_d;
      sd_wr_q     <= sd_wr_d;
    end
  end

`ifdef SD_PRUEFSUMME_EN
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      xor_q        <= '0;
      pruef_done_q <= 1'b0;
    end else begin
      xor_q        <= xor_d;
      pruef_done_q <= pruef_done_d;
    end
  end
`endif

  assign Busy            = busy_q;
  assign Fertig          = fertig_q;
  assign Fehler          = fehler_q;
  assign bus.RAMLesenAn  = ram_lesen_q;
  assign bus.RAMAdresse  = ram_adr_q;
  assign bus.SDAdresse   = sd_adr_q;
  assign bus.SDDaten     = sd_dat_q;
  assign bus.SDSchreiben = sd_wr_q;
endmodule

// File: tb/tb_sd_speicherer.sv
// Directed bench for sd_speicherer: RAM model with 2-cycle latency, SD writer model with optional busy.
module tb_sd_speicherer;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned GAP    = 31;
`ifdef SD_PRUEFSUMME_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_adr;
  logic [31:0]       wc;
  logic [31:0]       basis;
  logic              busy, fertig, fehler;

  sd_speicherer_if #(.ADDR_W(ADDR_W)) bus ();

  sd_speicherer #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .Clock       (clk),
    .ResetN      (rst_n),
    .Start       (start),
    .StartAdresse(start_adr),
    .Wortanzahl  (wc),
    .SDBasis     (basis),
    .Busy        (busy),
    .Fertig      (fertig),
    .Fehler      (fehler),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RAM model
  logic [31:0] mem [0:32767];
  logic        ram_wait = 1'b0;
  logic        ram_bereit = 1'b0;
  logic [31:0] ram_daten = '0;
  int          ram_n = 0;
  logic [ADDR_W-1:0] ram_log [0:255];

  assign bus.RAMDatenBereit = ram_bereit;
  assign bus.RAMDatenRaus   = ram_daten;

  always @(posedge clk) begin
    ram_bereit <= 1'b0;
    if (ram_wait) begin
      ram_wait   <= 1'b0;
      ram_bereit <= 1'b1;
      ram_daten  <= mem[bus.RAMAdresse];
    end else if (bus.RAMLesenAn && !ram_bereit) begin
      ram_wait <= 1'b1;
      if (ram_n < 256) ram_log[ram_n] <= bus.RAMAdresse;
      ram_n <= ram_n + 1;
    end
  end

  // SD writer model
  logic busy_mode = 1'b0;
  int   busy_cnt = 0;
  assign bus.SDBusy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (bus.SDSchreiben && busy_mode) busy_cnt <= 50;
  end

  // Monitor
  int          cyc = 0, low_run = 0, sd_n = 0, fertig_n = 0, fehler_n = 0, fertig_busy_n = 0;
  logic [31:0] sd_a [0:255];
  logic [31:0] sd_d [0:255];
  int          sd_cyc [0:255];
  int          sd_low [0:255];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fertig) fertig_n <= fertig_n + 1;
    if (fertig && busy) fertig_busy_n <= fertig_busy_n + 1;
    if (fehler) fehler_n <= fehler_n + 1;
    if (bus.SDSchreiben) begin
      if (sd_n < 256) begin
        sd_a[sd_n]   <= bus.SDAdresse;
        sd_d[sd_n]   <= bus.SDDaten;
        sd_cyc[sd_n] <= cyc;
        sd_low[sd_n] <= low_run;
      end
      sd_n    <= sd_n + 1;
      low_run <= 0;
    end else if (bus.SDBusy) begin
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [31:0] n, input logic [31:0] b);
    @(negedge clk);
    start_adr = a;
    wc        = n;
    basis     = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_fertig(input int f0);
    int n = 0;
    while (fertig_n == f0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_adr = '0;
    wc = '0;
    basis = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, fertig, fehler} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b expected 000", {busy, fertig, fehler});
    end
    checks++;
    if ({bus.RAMLesenAn, bus.SDSchreiben} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes got %b expected 00", {bus.RAMLesenAn, bus.SDSchreiben});
    end
    checks++;
    if (bus.RAMAdresse !== '0) begin
      errors++; $display("FAIL reset_ramadr got %h expected 0", bus.RAMAdresse);
    end
    checks++;
    if ({bus.SDAdresse, bus.SDDaten} !== 64'h0) begin
      errors++; $display("FAIL reset_sdbus got %h %h expected 0 0", bus.SDAdresse, bus.SDDaten);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s0 = sd_n;
    int f0 = fertig_n;
    logic [31:0] ea [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    logic [31:0] ed [4] = '{32'h2, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
    mem[15'h10] = 32'hDEAD_BEEF;
    mem[15'h11] = 32'h1234_5678;
    mem[15'h12] = 32'hCAFE_F00D;
    start_xfer(15'h10, 32'd3, 32'h100);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b expected 1", busy);
    end
    wait_fertig(f0);
    checks++;
    if (sd_n - s0 != 4 + EXTRA) begin
      errors++; $display("FAIL basic_pulses got %0d expected %0d", sd_n - s0, 4 + EXTRA);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sd_a[s0+i] !== ea[i] || sd_d[s0+i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write%0d got (%h,%h) expected (%h,%h)", i, sd_a[s0+i], sd_d[s0+i], ea[i], ed[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (sd_cyc[s0+i] - sd_cyc[s0+i-1] < int'(GAP) + 1) begin
        errors++;
        $display("FAIL basic_spacing%0d got %0d expected >= %0d", i, sd_cyc[s0+i] - sd_cyc[s0+i-1], GAP + 1);
      end
    end
    checks++;
    if (fertig_n - f0 != 1) begin
      errors++; $display("FAIL basic_fertig got %0d expected 1", fertig_n - f0);
    end
    checks++;
    if (busy !== 1'b0 || fertig_busy_n != 0) begin
      errors++; $display("FAIL basic_busy_end got busy=%b overlap=%0d expected 0 0", busy, fertig_busy_n);
    end
  endtask

  task automatic test_zero();
    int s0 = sd_n;
    int r0 = ram_n;
    int e0 = fehler_n;
    start_xfer(15'h20, 32'd0, 32'h200);
    checks++;
    if ({fehler, busy} !== 2'b10) begin
      errors++; $display("FAIL zero_fehler got fehler,busy=%b expected 10", {fehler, busy});
    end
    @(negedge clk);
    checks++;
    if ({fehler, busy} !== 2'b00) begin
      errors++; $display("FAIL zero_fehler_drop got fehler,busy=%b expected 00", {fehler, busy});
    end
    repeat (40) @(negedge clk);
    checks++;
    if (sd_n != s0 || ram_n != r0 || fehler_n - e0 != 1) begin
      errors++;
      $display("FAIL zero_activity got sd=%0d ram=%0d fehler=%0d expected 0 0 1", sd_n - s0, ram_n - r0, fehler_n - e0);
    end
  endtask

  task automatic test_sd_busy();
    int s0 = sd_n;
    int f0 = fertig_n;
    mem[15'h30] = 32'h0000_1111;
    mem[15'h31] = 32'h2222_0000;
    busy_mode = 1'b1;
    start_xfer(15'h30, 32'd2, 32'h400);
    wait_fertig(f0);
    busy_mode = 1'b0;
    checks++;
    if (sd_n - s0 != 3 + EXTRA) begin
      errors++; $display("FAIL busy_pulses got %0d expected %0d", sd_n - s0, 3 + EXTRA);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (sd_low[s0+i] < int'(GAP) + 1) begin
        errors++; $display("FAIL busy_gap%0d got %0d expected >= %0d", i, sd_low[s0+i], GAP + 1);
      end
    end
    checks++;
    if (sd_a[s0+2] !== 32'h402 || sd_d[s0+2] !== 32'h2222_0000) begin
      errors++; $display("FAIL busy_write2 got (%h,%h) expected (402,22220000)", sd_a[s0+2], sd_d[s0+2]);
    end
  endtask

  task automatic test_reset_mid();
    int s0 = sd_n;
    int f0 = fertig_n;
    int n = 0;
    mem[15'h40] = 32'hAAAA_0000;
    mem[15'h41] = 32'hBBBB_0000;
    mem[15'h42] = 32'hCCCC_0000;
    start_xfer(15'h40, 32'd3, 32'h500);
    while (sd_n < s0 + 2 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (bus.RAMLesenAn !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, fertig, fehler, bus.RAMLesenAn, bus.SDSchreiben} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs got %b expected 00000", {busy, fertig, fehler, bus.RAMLesenAn, bus.SDSchreiben});
    end
    checks++;
    if ({bus.SDAdresse, bus.SDDaten} !== 64'h0 || bus.RAMAdresse !== '0) begin
      errors++; $display("FAIL midreset_buses got %h %h %h expected 0", bus.SDAdresse, bus.SDDaten, bus.RAMAdresse);
    end
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (sd_n - s0 != 2 || fertig_n != f0) begin
      errors++; $display("FAIL midreset_abort got pulses=%0d fertig=%0d expected 2 0", sd_n - s0, fertig_n - f0);
    end
  endtask

  task automatic test_wrap();
    int s0 = sd_n;
    int r0 = ram_n;
    int f0 = fertig_n;
    mem[15'h7FFF] = 32'h7777_7777;
    mem[15'h0000] = 32'h0000_0001;
    start_xfer(15'h7FFF, 32'd2, 32'hFFFF_FFFE);
    wait_fertig(f0);
    checks++;
    if (ram_n - r0 != 2 || ram_log[r0] !== 15'h7FFF || ram_log[r0+1] !== 15'h0000) begin
      errors++;
      $display("FAIL wrap_ramadr got n=%0d %h %h expected 2 7fff 0000", ram_n - r0, ram_log[r0], ram_log[r0+1]);
    end
    checks++;
    if (sd_a[s0+1] !== 32'hFFFF_FFFF || sd_d[s0+1] !== 32'h7777_7777) begin
      errors++; $display("FAIL wrap_write1 got (%h,%h) expected (ffffffff,77777777)", sd_a[s0+1], sd_d[s0+1]);
    end
    checks++;
    if (sd_a[s0+2] !== 32'h0 || sd_d[s0+2] !== 32'h1) begin
      errors++; $display("FAIL wrap_write2 got (%h,%h) expected (0,1)", sd_a[s0+2], sd_d[s0+2]);
    end
  endtask

  task automatic test_checksum_busy_start();
    int s0 = sd_n;
    int f0 = fertig_n;
    int e0 = fehler_n;
    mem[15'h50] = 32'h0000_000F;
    mem[15'h51] = 32'h0000_00F0;
    start_xfer(15'h50, 32'd2, 32'h600);
    repeat (3) @(negedge clk);
    start_xfer(15'h60, 32'd0, 32'h700);
    repeat (40) @(negedge clk);
    start_xfer(15'h60, 32'd5, 32'h800);
    wait_fertig(f0);
    repeat (100) @(negedge clk);
    checks++;
    if (sd_n - s0 != 3 + EXTRA || fertig_n - f0 != 1 || fehler_n != e0) begin
      errors++;
      $display("FAIL busystart_ignored got pulses=%0d fertig=%0d fehler=%0d expected %0d 1 0",
               sd_n - s0, fertig_n - f0, fehler_n - e0, 3 + EXTRA);
    end
    checks++;
    if (sd_a[s0] !== 32'h600 || sd_d[s0] !== 32'h1) begin
      errors++; $display("FAIL busystart_header got (%h,%h) expected (600,1)", sd_a[s0], sd_d[s0]);
    end
    checks++;
    if (sd_a[s0+2] !== 32'h602 || sd_d[s0+2] !== 32'hF0) begin
      errors++; $display("FAIL busystart_write2 got (%h,%h) expected (602,f0)", sd_a[s0+2], sd_d[s0+2]);
    end
`ifdef SD_PRUEFSUMME_EN
    checks++;
    if (sd_a[s0+3] !== 32'h603 || sd_d[s0+3] !== 32'hFF) begin
      errors++; $display("FAIL checksum_write got (%h,%h) expected (603,ff)", sd_a[s0+3], sd_d[s0+3]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_sd_busy();
    test_reset_mid();
    test_wrap();
    test_checksum_busy_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
